femul_arb: RTL and testbench
============================

# femul_arb

Round-robin arbiter and sequencer that shares one `femul` (GF(2^255-19) multiplier) between `NREQ` independent requesters. It accepts one operand pair at a time over per-requester valid/ready handshakes and drives the multiplier's `start`/`done` protocol. It returns each product tagged with the requester index. It sits between the curve-arithmetic clients (ladder step, inversion, point encode) and the single `femul` instance owned by the parent.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `IDW`, default `$clog2(NREQ)`: requester-index width.

- `clock`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NREQ  requester i has an operand pair pending.
- `req_ready`  out  NREQ  one-hot or zero; transfer on `req_valid[i] & req_ready[i]`.
- `req_a`, `req_b`  in  NREQ x 255  operands per requester; any 255-bit value, including values >= p.
- `rsp_valid`  out  1  one-cycle pulse: product available.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_data`.
- `rsp_data`  out  255  product mod 2^255-19, exactly as produced by `femul`.
- `fm_start`  out  1  to `femul` start.
- `fm_a`, `fm_b`  out  255  to `femul` operands.
- `fm_done`  in  1  from `femul` done.
- `fm_out`  in  255  from `femul` result.
- `ops_count`  out  32  completed-operation count (see Configuration).

## Operation
- The FSM has four states: IDLE, ISSUE, SKIP, WAIT.
- **IDLE**
  - The picker selects the first i with `req_valid[i]`, searching from `last+1` modulo NREQ. Only that `req_ready[i]` is driven high.
  - `req_ready` is combinational from `req_valid` and the state, and is 0 outside IDLE.
  - On transfer, the block latches `req_a[i]`, `req_b[i]` into `fm_a`/`fm_b`, latches i into the id register, sets `last <= i`, and moves to ISSUE.
- **ISSUE**: `fm_start=1` for exactly this cycle. Next state is SKIP.
- **SKIP**: one cycle in which `fm_done` is ignored, because it may still show the previous op's level. Next state is WAIT.
- **WAIT**
  - On `fm_done=1`, the block registers `fm_out` into `rsp_data` and the id register into `rsp_id`, sets `rsp_valid` for the next cycle, and moves to IDLE.
  - The block stays in WAIT indefinitely while `fm_done=0`; there is no timeout.
- `fm_a`/`fm_b` hold stable from ISSUE through the WAIT exit cycle. They change only on the next IDLE transfer.
- Requesters must hold `req_valid` and their operands stable until `req_ready`. Dropping valid before the grant is permitted; that request is simply not taken.
- The response has no backpressure. Requesters must accept `rsp_valid` whenever it is addressed to them.
- `fm_done` is ignored in IDLE, ISSUE and SKIP.
- With a single active requester, it is granted on every IDLE visit.
- A request that arrives during a busy period waits. Round-robin guarantees grant within NREQ operations.
- **Reset**, including mid-operation:
  - state to IDLE, `last` to NREQ-1 (requester 0 wins first), `fm_start=0`, `rsp_valid=0`, `req_ready=0`, `rsp_id=0`, `rsp_data=0`, `fm_a=fm_b=0`, `ops_count=0`.
  - An in-flight product is discarded, with no `rsp_valid`.
  - The next ISSUE restarts `femul`, and its stale `done` is masked by SKIP.

## Timing
- Transfer in cycle t gives `fm_start` at t+1.
- Say the first `fm_done` seen in WAIT is at cycle d >= t+3. Then `rsp_valid` is at d+1, and the FSM is in IDLE at d+1.
- A new transfer may occur in cycle d+1, concurrent with `rsp_valid`.
- Arbiter overhead per op is 3 cycles plus the `femul` latency.

## Configuration
- `FEMUL_ARB_STATS_EN` defined:
  - `ops_count` increments by 1 on each `rsp_valid` and saturates at 2^32-1.
  - It is cleared by reset.
- `FEMUL_ARB_STATS_EN` undefined: `ops_count` is tied to 0 and no counter flops exist.

## Structure
- Package `femul_pkg` holds:
  - `fe_t` (logic [254:0]);
  - `FE_P` (2^255-19);
  - the `femul_arb_state_t` enum {IDLE, ISSUE, SKIP, WAIT}.
- Sub-module `femul_rr_pick` is combinational: it takes `req` (NREQ) and `last` (IDW), and produces `gnt_oh` (NREQ), `gnt_id` (IDW) and `any`.
- `femul` itself is instantiated by the parent or the bench, not inside this block.

## Test plan
- Req 0 sends a=b=1<<128, with a real `femul` attached. Expect one `rsp_valid`, `rsp_id=0`, `rsp_data=0x26`, and `fm_start` high exactly one cycle.
- Reqs 0..3 all valid simultaneously after reset, with operands (2^255-1, 1), (0x4000…0, 2), ((1<<128)-1, (1<<128)+1), (1<<128, 1<<128). Grants must occur in order 0,1,2,3, and the results must be 0x12, 19, 0x25, 0x26 with matching `rsp_id`.
- Req 2 held permanently valid while req 1 pulses valid once. Req 1 must be granted within 2 ops; check that req 2 is never granted twice in a row while req 1 waits.
- Stub `femul` holds `done=1` from the previous op. Expect no capture in ISSUE or SKIP, and the response taken only on the stub's new result.
- `reset` asserted in WAIT. Expect no `rsp_valid`, all outputs at reset values next cycle, and the next grant going to req 0.
- With `FEMUL_ARB_STATS_EN`, 5 completed ops give `ops_count=5`. Without the macro, `ops_count=0` throughout.

Source files
------------

// File: rtl/femul_pkg.sv
// Shared field-element type, modulus and arbiter state encoding for the
// GF(2^255-19) multiplier front end.
package femul_pkg;

  typedef logic [254:0] fe_t;

  localparam fe_t FE_P = {255{1'b1}} - fe_t'(18);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SKIP,
    WAIT
  } femul_arb_state_t;

endpackage

// File: rtl/femul_rr_pick.sv
// Combinational round-robin picker: grants the first requester found when
// searching upward from last+1, wrapping modulo NREQ.
module femul_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  int best;

  // Each requester's distance from last+1; the smallest requesting distance wins.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    best   = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (((i + NREQ - 1 - int'(last)) % NREQ) < best)) begin
        best   = (i + NREQ - 1 - int'(last)) % NREQ;
        gnt_id = IDW'(i);
        any    = 1'b1;
      end
    end
  end

  assign gnt_oh = any ? (NREQ'(1) << gnt_id) : '0;

endmodule

// File: rtl/femul_arb.sv
// Round-robin arbiter/sequencer sharing one femul between NREQ requesters.
// Optional FEMUL_ARB_STATS_EN adds a saturating completed-operation counter.
module femul_arb
  import femul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  fe_t  [NREQ-1:0]      req_a,
  input  fe_t  [NREQ-1:0]      req_b,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output fe_t                  rsp_data,
  output logic                 fm_start,
  output fe_t                  fm_a,
  output fe_t                  fm_b,
  input  logic                 fm_done,
  input  fe_t                  fm_out,
  output logic [31:0]          ops_count
);

  femul_arb_state_t state, state_nx;
  logic [IDW-1:0]   last, id_q, gnt_id;
  logic [NREQ-1:0]  gnt_oh;
  logic             any_req;

  femul_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req_valid),
    .last   (last),
    .gnt_oh (gnt_oh),
    .gnt_id (gnt_id),
    .any    (any_req)
  );

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    fm_start  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = reset ? '0 : gnt_oh;
        if (any_req) state_nx = ISSUE;
      end
      ISSUE: begin
        fm_start = 1'b1;
        state_nx = SKIP;
      end
      // fm_done may still show the previous operation's level here.
      SKIP: state_nx = WAIT;
      WAIT: if (fm_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      last      <= IDW'(NREQ - 1);
      id_q      <= '0;
      fm_a      <= '0;
      fm_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nx;
      rsp_valid <= 1'b0;
      if (state == IDLE && any_req) begin
        fm_a <= req_a[gnt_id];
        fm_b <= req_b[gnt_id];
        id_q <= gnt_id;
        last <= gnt_id;
      end
      if (state == WAIT && fm_done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_data  <= fm_out;
      end
    end
  end

`ifdef FEMUL_ARB_STATS_EN
  logic [31:0] ops_q;

  always_ff @(posedge clock) begin
    if (reset)                          ops_q <= '0;
    else if (rsp_valid && ops_q != '1)  ops_q <= ops_q + 32'd1;
  end

  assign ops_count = ops_q;
`else
  assign ops_count = '0;
`endif

endmodule

// File: tb/tb_femul_arb.sv
// Bench for femul_arb: behavioural femul stub, per-cycle reference model and
// directed scenarios with hand-computed products.
module tb_femul_arb;
  import femul_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam fe_t JUNK = fe_t'(64'hDEAD_BEEF_0BAD_F00D);
`ifdef FEMUL_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  fe_t  [NREQ-1:0] req_a, req_b;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  fe_t             rsp_data;
  logic            fm_start;
  fe_t             fm_a, fm_b;
  logic            fm_done = 1'b0;
  fe_t             fm_out = '0;
  logic [31:0]     ops_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  femul_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .fm_start(fm_start), .fm_a(fm_a), .fm_b(fm_b),
    .fm_done(fm_done), .fm_out(fm_out), .ops_count(ops_count)
  );

  task automatic check(input string name, input logic [254:0] act, input logic [254:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic fe_t mulmod(input fe_t a, input fe_t b);
    logic [509:0] prod;
    prod = {255'b0, a} * {255'b0, b};
    return fe_t'(prod % {255'b0, FE_P});
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // femul stub: done is a level that holds until the next start. In stale
  // mode the old done level survives one extra cycle with a junk result.
  int  lat = 4;
  bit  stale_mode = 1'b0;
  fe_t st_a, st_b;
  int  st_cnt = 0;
  bit  st_run = 1'b0, st_hold = 1'b0;

  always @(posedge clock) begin
    if (fm_start) begin
      st_a   <= fm_a;
      st_b   <= fm_b;
      st_cnt <= lat;
      st_run <= 1'b1;
      if (stale_mode) begin
        st_hold <= 1'b1;
        fm_out  <= JUNK;
      end else begin
        fm_done <= 1'b0;
      end
    end else if (st_hold) begin
      st_hold <= 1'b0;
      fm_done <= 1'b0;
    end else if (st_run) begin
      if (st_cnt <= 1) begin
        st_run  <= 1'b0;
        fm_done <= 1'b1;
        fm_out  <= mulmod(st_a, st_b);
      end else begin
        st_cnt <= st_cnt - 1;
      end
    end
  end

  // Reference model: busy flag plus cycles elapsed since the grant.
  bit          m_ok = 1'b0, m_busy, m_rv;
  int          m_age, m_last, m_id, m_rid;
  fe_t         m_a, m_b, m_rdata;
  logic [31:0] m_ops;

  int  gnt_log[$];
  int  rsp_id_log[$];
  fe_t rsp_data_log[$];
  int  start_cnt = 0, rsp_cnt = 0;

  always @(negedge clock) begin
    logic [NREQ-1:0] exp_ready;
    int g;
    g = m_ok ? pick(req_valid, m_last) : -1;
    exp_ready = '0;
    if (m_ok) begin
      if (!m_busy && !reset && g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("fm_start", fm_start, m_busy && m_age == 1);
      check("rsp_valid", rsp_valid, m_rv);
      check("rsp_id", rsp_id, m_rid);
      check("rsp_data", rsp_data, m_rdata);
      check("fm_a", fm_a, m_a);
      check("fm_b", fm_b, m_b);
      check("ops_count", ops_count, m_ops);
    end
    if (fm_start) start_cnt++;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_id_log.push_back(int'(rsp_id));
      rsp_data_log.push_back(rsp_data);
    end
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) gnt_log.push_back(i);

    if (reset) begin
      m_ok = 1'b1; m_busy = 1'b0; m_rv = 1'b0; m_age = 0;
      m_last = NREQ - 1; m_id = 0; m_rid = 0;
      m_a = '0; m_b = '0; m_rdata = '0; m_ops = '0;
    end else if (m_ok) begin
      if (m_rv && STATS && m_ops != 32'hFFFF_FFFF) m_ops = m_ops + 1;
      m_rv = 1'b0;
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1'b1; m_age = 1; m_id = g; m_last = g;
          m_a = req_a[g]; m_b = req_b[g];
        end
      end else if (m_age < 3) begin
        m_age++;
      end else if (fm_done) begin
        m_busy = 1'b0; m_rv = 1'b1; m_rid = m_id; m_rdata = mulmod(m_a, m_b);
      end
    end
  end

  // Requester side: drop valid after the transfer unless the requester is sticky.
  logic [NREQ-1:0] sticky = '0;
  initial forever begin
    logic [NREQ-1:0] drop;
    @(negedge clock);
    drop = req_valid & req_ready & ~sticky;
    @(posedge clock);
    #1 req_valid = req_valid & ~drop;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
  endtask

  task automatic post(input int i, input fe_t a, input fe_t b);
    req_a[i] = a;
    req_b[i] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_rsps(input int target, input int budget, input string name);
    int n = 0;
    while (rsp_cnt < target && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    check(name, rsp_cnt >= target, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  fe_t p128;
  int  r0, s0, gl, g1start, n2, n;
  bit  found;

  initial begin
    req_a = '0;
    req_b = '0;
    p128  = fe_t'(1) << 128;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    cycles(1);

    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_fm_a", fm_a, 0);
    check("rst_ops", ops_count, 0);

    // Single op: 2^256 mod p = 38
    s0 = start_cnt; r0 = rsp_cnt;
    post(0, p128, p128);
    wait_rsps(r0 + 1, 50, "t1_done");
    cycles(3);
    check("t1_start_pulses", start_cnt - s0, 1);
    check("t1_rsp_count", rsp_cnt - r0, 1);
    check("t1_id", rsp_id_log[r0], 0);
    check("t1_data", rsp_data_log[r0], 255'h26);

    // All four at once after reset: grant order 0,1,2,3
    do_reset();
    r0 = rsp_cnt; gl = gnt_log.size();
    post(0, '1, 1);
    post(1, fe_t'(1) << 254, 2);
    post(2, p128 - 1, p128 + 1);
    post(3, p128, p128);
    wait_rsps(r0 + 4, 100, "t2_done");
    for (int k = 0; k < 4; k++) begin
      check("t2_grant_order", gnt_log[gl + k], k);
      check("t2_rsp_id", rsp_id_log[r0 + k], k);
    end
    check("t2_data0", rsp_data_log[r0],     255'h12);
    check("t2_data1", rsp_data_log[r0 + 1], 255'd19);
    check("t2_data2", rsp_data_log[r0 + 2], 255'h25);
    check("t2_data3", rsp_data_log[r0 + 3], 255'h26);

    // Req 2 always valid, req 1 arrives mid-op: no double grant of 2 ahead of 1
    r0 = rsp_cnt; gl = gnt_log.size();
    sticky[2] = 1'b1;
    post(2, 7, 9);
    cycles(2);
    g1start = gnt_log.size();
    post(1, 11, 13);
    found = 1'b0; n = 0;
    while (!found && n < 60) begin
      @(posedge clock);
      n++;
      for (int k = g1start; k < gnt_log.size(); k++) if (gnt_log[k] == 1) found = 1'b1;
    end
    #1;
    check("t3_req1_granted", found, 1'b1);
    n2 = 0;
    for (int k = g1start; k < gnt_log.size() && gnt_log[k] != 1; k++) if (gnt_log[k] == 2) n2++;
    check("t3_no_double_grant", n2 <= 1, 1'b1);
    wait_rsps(r0 + 4, 100, "t3_done");
    check("t3_g0", gnt_log[gl], 2);
    check("t3_g1", gnt_log[gl + 1], 1);
    check("t3_g2", gnt_log[gl + 2], 2);
    check("t3_g3", gnt_log[gl + 3], 2);
    check("t3_req1_data", rsp_data_log[r0 + 1], 255'd143);
    sticky[2] = 1'b0;
    req_valid[2] = 1'b0;
    cycles(30);

    // Stale done level from the previous op must be ignored
    stale_mode = 1'b1;
    r0 = rsp_cnt;
    post(3, 3, 5);
    wait_rsps(r0 + 1, 50, "t4_done");
    cycles(2);
    check("t4_count", rsp_cnt - r0, 1);
    check("t4_id", rsp_id_log[r0], 3);
    check("t4_data", rsp_data_log[r0], 255'd15);
    stale_mode = 1'b0;

    // Reset while waiting on a long op
    lat = 20;
    r0 = rsp_cnt;
    post(1, 2, 3);
    cycles(6);
    do_reset();
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_fm_start", fm_start, 0);
    check("t5_fm_a", fm_a, 0);
    check("t5_fm_b", fm_b, 0);
    check("t5_rsp_id", rsp_id, 0);
    check("t5_rsp_data", rsp_data, 0);
    check("t5_ops", ops_count, 0);
    cycles(30);
    check("t5_no_rsp", rsp_cnt - r0, 0);
    lat = 4;
    gl = gnt_log.size(); r0 = rsp_cnt;
    post(3, 4, 4);
    post(1, 5, 5);
    post(0, 6, 6);
    wait_rsps(r0 + 3, 100, "t5_done");
    check("t5_first_grant", gnt_log[gl], 0);
    check("t5_data0", rsp_data_log[r0], 255'd36);

    // Five completed ops since reset
    post(2, 1, 1);
    wait_rsps(r0 + 4, 50, "t6_op4");
    post(2, 2, 2);
    wait_rsps(r0 + 5, 50, "t6_op5");
    cycles(3);
    check("t6_ops_count", ops_count, STATS ? 32'd5 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
